// File: rtl/mem_stage_master_pkg.sv
// rtl/mem_stage_master_pkg.sv - shared encodings and constants for the MEM-stage memory initiator
package mem_stage_master_pkg;

    localparam int          FLAGS_W   = 4;
    localparam int          ADDR_W_D  = 11;
    localparam logic [10:0] STACK_TOP = 11'h7FE;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDD  = 3'd1,
        OP_STD  = 3'd2,
        OP_PUSH = 3'd3,
        OP_POP  = 3'd4,
        OP_INT  = 3'd5,
        OP_RTI  = 3'd6,
        OP_RSV  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/mem_stage_master.sv
// rtl/mem_stage_master.sv - MEM-stage initiator sequencing loads, stores, stack ops and INT/RTI frames
module mem_stage_master
    import mem_stage_master_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_D,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(STACK_TOP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [FLAGS_W-1:0] req_flags,
    output logic               resp_valid,
    output logic [31:0]        resp_data,
    output logic [FLAGS_W-1:0] resp_flags,
    output logic [ADDR_W-1:0]  sp,
    output logic               stk_ovf,
    output logic               stk_unf,
    output logic [31:0]        Address,
    output logic [31:0]        Write_Data,
    output logic               MW,
    output logic               MR,
    input  logic [31:0]        Read_Data
);

    localparam logic [ADDR_W-1:0] SP_TWO  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] SP_FOUR = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] POP_LIM = SP_INIT - SP_TWO;
    localparam logic [ADDR_W-1:0] RTI_LIM = SP_INIT - SP_FOUR;

    state_e               r_state, w_state;
    op_e                  r_op, w_op, w_req_op;
    logic [FLAGS_W-1:0]   r_flags, w_flags;
    logic [FLAGS_W-1:0]   r_rd_flags, w_rd_flags;
    logic [ADDR_W-1:0]    r_sp, w_sp;
    logic                 r_ovf, w_ovf;
    logic                 r_unf, w_unf;
    logic [ADDR_W-1:0]    r_addr, w_addr;
    logic [31:0]          r_wdata, w_wdata;
    logic                 r_mw, w_mw;
    logic                 r_mr, w_mr;
    logic                 r_resp_valid, w_resp_valid;
    logic [31:0]          r_resp_data, w_resp_data;
    logic [FLAGS_W-1:0]   r_resp_flags, w_resp_flags;
    logic                 w_unused_addr;

    assign w_unused_addr = ^req_addr[31:ADDR_W];
    assign w_req_op      = op_e'(req_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_NOP;
            r_flags      <= '0;
            r_rd_flags   <= '0;
            r_sp         <= SP_INIT;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mw         <= 1'b0;
            r_mr         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
        end else begin
            r_state      <= w_state;
            r_op         <= w_op;
            r_flags      <= w_flags;
            r_rd_flags   <= w_rd_flags;
            r_sp         <= w_sp;
            r_ovf        <= w_ovf;
            r_unf        <= w_unf;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_mw         <= w_mw;
            r_mr         <= w_mr;
            r_resp_valid <= w_resp_valid;
            r_resp_data  <= w_resp_data;
            r_resp_flags <= w_resp_flags;
        end
    end

    // Memory-side outputs are registered, so each state computes the access for the next cycle.
    always_comb begin
        w_state      = r_state;
        w_op         = r_op;
        w_flags      = r_flags;
        w_rd_flags   = r_rd_flags;
        w_sp         = r_sp;
        w_ovf        = r_ovf;
        w_unf        = r_unf;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_mw         = 1'b0;
        w_mr         = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_data  = r_resp_data;
        w_resp_flags = r_resp_flags;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_op    = w_req_op;
                    w_flags = req_flags;
                    w_state = ST_ACC1;
                    case (w_req_op)
                        OP_LDD:  begin w_addr = req_addr[ADDR_W-1:0]; w_mr = 1'b1; end
                        OP_STD:  begin w_addr = req_addr[ADDR_W-1:0]; w_wdata = req_wdata; w_mw = 1'b1; end
                        OP_PUSH: begin w_addr = r_sp; w_wdata = req_wdata; w_mw = 1'b1; end
                        OP_POP:  begin w_addr = r_sp + SP_TWO; w_mr = 1'b1; end
                        OP_INT:  begin w_addr = r_sp; w_wdata = req_wdata; w_mw = 1'b1; end
                        OP_RTI:  begin w_addr = r_sp + SP_TWO; w_mr = 1'b1; end
                        default: w_state = ST_IDLE;
                    endcase
                end
            end
            ST_ACC1: begin
                w_state      = ST_RESP;
                w_resp_valid = 1'b1;
                w_resp_data  = '0;
                w_resp_flags = '0;
                case (r_op)
                    OP_LDD: w_resp_data = Read_Data;
                    OP_PUSH: begin
                        w_sp = r_sp - SP_TWO;
                        if (r_sp < SP_TWO) w_ovf = 1'b1;
                    end
                    OP_POP: begin
                        w_sp        = r_sp + SP_TWO;
                        w_resp_data = Read_Data;
                        if (r_sp > POP_LIM) w_unf = 1'b1;
                    end
                    OP_INT: begin
                        w_state      = ST_ACC2;
                        w_resp_valid = 1'b0;
                        w_addr       = r_sp - SP_TWO;
                        w_wdata      = {{(32-FLAGS_W){1'b0}}, r_flags};
                        w_mw         = 1'b1;
                        if (r_sp < SP_FOUR) w_ovf = 1'b1;
                    end
                    OP_RTI: begin
                        w_state      = ST_ACC2;
                        w_resp_valid = 1'b0;
                        w_rd_flags   = Read_Data[FLAGS_W-1:0];
                        w_addr       = r_sp + SP_FOUR;
                        w_mr         = 1'b1;
                        if (r_sp > RTI_LIM) w_unf = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_ACC2: begin
                w_state      = ST_RESP;
                w_resp_valid = 1'b1;
                if (r_op == OP_RTI) begin
                    w_sp         = r_sp + SP_FOUR;
                    w_resp_data  = Read_Data;
                    w_resp_flags = r_rd_flags;
                end else begin
                    w_sp         = r_sp - SP_FOUR;
                    w_resp_data  = '0;
                    w_resp_flags = '0;
                end
            end
            ST_RESP: w_state = ST_IDLE;
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_flags = r_resp_flags;
    assign sp         = r_sp;
    assign stk_ovf    = r_ovf;
    assign stk_unf    = r_unf;
    assign Address    = {{(32-ADDR_W){1'b0}}, r_addr};
    assign Write_Data = r_wdata;
    assign MW         = r_mw;
    assign MR         = r_mr;

endmodule

// File: tb/tb_mem_stage_master.sv
// tb/tb_mem_stage_master.sv - table-driven scoreboard bench for mem_stage_master
module tb_mem_stage_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_flags = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [3:0]  resp_flags;
    logic [10:0] sp;
    logic        stk_ovf, stk_unf;
    logic [31:0] Address, Write_Data, Read_Data;
    logic        MW, MR;

    mem_stage_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_flags(req_flags),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
        .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
        .Address(Address), .Write_Data(Write_Data), .MW(MW), .MR(MR),
        .Read_Data(Read_Data)
    );

    always #5 clk = ~clk;

    // Halfword memory: 32-bit word at A is {mem[A+1], mem[A]}, A+1 wraps at 2047.
    logic [15:0] mem [0:2047];
    logic [10:0] a0, a1;
    assign a0 = Address[10:0];
    assign a1 = a0 + 11'd1;
    assign Read_Data = {mem[a1], mem[a0]};
    always @(posedge clk) begin
        if (MW) begin
            mem[a0] <= Write_Data[15:0];
            mem[a1] <= Write_Data[31:16];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t       sbq[$];
    logic [10:0] addr_log[$];

    always @(negedge clk) begin
        if (MW && MR) chk("mw_mr_exclusive", 32'd1, 32'd0);
        if (MW || MR) addr_log.push_back(Address[10:0]);
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_flags", {28'd0, resp_flags}, {28'd0, e.flags});
                chk("resp_latency", cyc - e.acc_cyc, e.lat);
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  flags;
        logic [31:0] exp_data;
        logic [3:0]  exp_flags;
        logic [10:0] exp_sp;
        logic        exp_ovf;
        logic        exp_unf;
        int          exp_lat;
        int          exp_acc;
        logic [10:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] flags, input logic [31:0] ed, input logic [3:0] ef,
                                input logic [10:0] esp, input logic eo, input logic eu,
                                input int lat, input int acc, input logic [10:0] ea);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.flags = flags;
        v.exp_data = ed; v.exp_flags = ef; v.exp_sp = esp; v.exp_ovf = eo; v.exp_unf = eu;
        v.exp_lat = lat; v.exp_acc = acc; v.exp_addr = ea;
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int base, n;
        exp_t e;
        wait_ready();
        base      = addr_log.size();
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_flags = v.flags;
        if (v.exp_acc > 0) begin
            e.data = v.exp_data; e.flags = v.exp_flags; e.acc_cyc = cyc; e.lat = v.exp_lat;
            sbq.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        req_flags = 4'($urandom);
        n = 0;
        while (sbq.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk($sformatf("resp_timeout[%0d]", idx), 32'd0, 32'd1);
            sbq.delete();
        end
        repeat (2) @(negedge clk);
        chk($sformatf("sp[%0d]", idx), {21'd0, sp}, {21'd0, v.exp_sp});
        chk($sformatf("ovf[%0d]", idx), {31'd0, stk_ovf}, {31'd0, v.exp_ovf});
        chk($sformatf("unf[%0d]", idx), {31'd0, stk_unf}, {31'd0, v.exp_unf});
        chk($sformatf("accesses[%0d]", idx), addr_log.size() - base, v.exp_acc);
        if (v.exp_acc > 0 && addr_log.size() > base)
            chk($sformatf("first_addr[%0d]", idx), {21'd0, addr_log[base]}, {21'd0, v.exp_addr});
    endtask

    vec_t tv[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        exp_t e;
        tv[0]  = mk(3'd2, 32'h010, 32'hDEADBEEF, 4'h0, 32'h0,        4'h0, 11'h7FE, 0, 0, 2, 1, 11'h010);
        tv[1]  = mk(3'd1, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 4'h0, 11'h7FE, 0, 0, 2, 1, 11'h010);
        tv[2]  = mk(3'd3, 32'h0,   32'h12345678, 4'h0, 32'h0,        4'h0, 11'h7FC, 0, 0, 2, 1, 11'h7FE);
        tv[3]  = mk(3'd4, 32'h0,   32'h0,        4'h0, 32'h12345678, 4'h0, 11'h7FE, 0, 0, 2, 1, 11'h7FE);
        tv[4]  = mk(3'd5, 32'h0,   32'h00000100, 4'hA, 32'h0,        4'h0, 11'h7FA, 0, 0, 3, 2, 11'h7FE);
        tv[5]  = mk(3'd6, 32'h0,   32'h0,        4'h0, 32'h00000100, 4'hA, 11'h7FE, 0, 0, 3, 2, 11'h7FC);
        tv[6]  = mk(3'd2, 32'h000, 32'h0BADC0DE, 4'h0, 32'h0,        4'h0, 11'h7FE, 0, 0, 2, 1, 11'h000);
        tv[7]  = mk(3'd2, 32'h7FF, 32'hCAFEF00D, 4'h0, 32'h0,        4'h0, 11'h7FE, 0, 0, 2, 1, 11'h7FF);
        tv[8]  = mk(3'd1, 32'hFFFF_F7FF, 32'h0,  4'h0, 32'hCAFEF00D, 4'h0, 11'h7FE, 0, 0, 2, 1, 11'h7FF);
        tv[9]  = mk(3'd1, 32'h000, 32'h0,        4'h0, 32'h0BADCAFE, 4'h0, 11'h7FE, 0, 0, 2, 1, 11'h000);
        tv[10] = mk(3'd4, 32'h0,   32'h0,        4'h0, 32'h0BADCAFE, 4'h0, 11'h000, 0, 1, 2, 1, 11'h000);
        tv[11] = mk(3'd2, 32'h020, 32'h11112222, 4'h0, 32'h0,        4'h0, 11'h000, 0, 1, 2, 1, 11'h020);
        tv[12] = mk(3'd3, 32'h0,   32'h55667788, 4'h0, 32'h0,        4'h0, 11'h7FE, 1, 1, 2, 1, 11'h000);
        tv[13] = mk(3'd0, 32'h030, 32'h99999999, 4'h0, 32'h0,        4'h0, 11'h7FE, 1, 1, 0, 0, 11'h000);
        tv[14] = mk(3'd7, 32'h030, 32'h99999999, 4'h0, 32'h0,        4'h0, 11'h7FE, 1, 1, 0, 0, 11'h000);

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_sp", {21'd0, sp}, 32'h7FE);
        chk("rst_mw_mr", {30'd0, MW, MR}, 32'd0);
        chk("rst_address", Address, 32'd0);
        chk("rst_wdata", Write_Data, 32'd0);
        chk("rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_flags", {28'd0, resp_flags}, 32'd0);
        chk("rst_flags", {30'd0, stk_ovf, stk_unf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(i, tv[i]);

        // Reset during INT second access abandons the frame.
        wait_ready();
        req_valid = 1'b1; req_op = 3'd5; req_wdata = 32'h200; req_flags = 4'h3;
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'd0;
        @(negedge clk);
        chk("int_acc2_mw", {31'd0, MW}, 32'd1);
        chk("int_acc2_addr", Address, 32'h7FC);
        chk("int_acc2_wdata", Write_Data, 32'h3);
        rst = 1'b1;
        #1;
        chk("rst_mid_mw", {31'd0, MW}, 32'd0);
        chk("rst_mid_sp", {21'd0, sp}, 32'h7FE);
        chk("rst_mid_flags", {30'd0, stk_ovf, stk_unf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_release_resp", {31'd0, resp_valid}, 32'd0);

        // req_valid held through ACC1 and RESP: only one accept.
        wait_ready();
        base = addr_log.size();
        req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h010;
        e.data = 32'hDEADBEEF; e.flags = 4'h0; e.acc_cyc = cyc; e.lat = 2;
        sbq.push_back(e);
        @(negedge clk);
        chk("hold_ready_acc1", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("hold_ready_resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'd0;
        repeat (4) @(negedge clk);
        chk("hold_single_accept", addr_log.size() - base, 32'd1);
        chk("hold_queue_drained", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
